// File: rtl/multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control : multicycle LEGv8-subset control FSM (Moore outputs,
//                      fetch/memory strobes gated by mem_ready)
// Revision: 1.0
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic        CLK,
  input  logic        Reset_L,
  input  logic [10:0] Opcode,
  input  logic        mem_ready,
  output logic [1:0]  ALUop,
  output logic        ALUSrc,
  output logic        Reg2Loc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        Branch,
  output logic        UncondBranch,
  output logic        instr_done,
  output logic        Illegal,
  output logic [3:0]  state
);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_WB_R   = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM    = 4'd6,
    S_WB_LD  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  state_t cur, nxt;
  logic   is_load;
  logic   is_rtype, is_mem, is_cbz, is_b;

  assign is_rtype = (Opcode == OP_ADD) || (Opcode == OP_SUB) ||
                    (Opcode == OP_AND) || (Opcode == OP_ORR);
  assign is_mem   = (Opcode == OP_LDUR) || (Opcode == OP_STUR);
  assign is_cbz   = (Opcode[10:3] == 8'b10110100);
  assign is_b     = (Opcode[10:5] == 6'b000101);
  assign state    = cur;

  // Load/store flavour is captured at DECODE so MEM does not depend on Opcode later
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      cur     <= S_RST;
      is_load <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) is_load <= (Opcode == OP_LDUR);
    end
  end

  always_comb begin
    nxt          = S_FETCH;
    ALUop        = 2'b00;
    ALUSrc       = 1'b0;
    Reg2Loc      = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    Branch       = 1'b0;
    UncondBranch = 1'b0;
    instr_done   = 1'b0;
    Illegal      = 1'b0;
    case (cur)
      S_RST: nxt = S_FETCH;
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nxt     = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        if (is_rtype)    nxt = S_EXEC_R;
        else if (is_mem) nxt = S_ADDR;
        else if (is_cbz) nxt = S_BRANCH;
        else if (is_b)   nxt = S_JUMP;
        else begin
          Illegal = 1'b1;
          nxt     = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUop = 2'b10;
        nxt   = S_WB_R;
      end
      S_WB_R: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_ADDR: begin
        ALUSrc = 1'b1;
        nxt    = S_MEM;
      end
      S_MEM: begin
        ALUSrc     = 1'b1;
        MemRead    = is_load;
        MemWrite   = !is_load;
        instr_done = mem_ready && !is_load;
        if (!mem_ready)   nxt = S_MEM;
        else if (is_load) nxt = S_WB_LD;
        else              nxt = S_FETCH;
      end
      S_WB_LD: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUop      = 2'b01;
        Reg2Loc    = 1'b1;
        Branch     = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        UncondBranch = 1'b1;
        instr_done   = 1'b1;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_control : instruction-level reference plans, random stimulus
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic [10:0] Opcode;
  logic        mem_ready;
  logic [1:0]  ALUop;
  logic        ALUSrc, Reg2Loc, MemRead, MemWrite, MemtoReg, RegWrite;
  logic        IRWrite, PCWrite, Branch, UncondBranch, instr_done, Illegal;
  logic [3:0]  state;

  multicycle_control dut (
    .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .mem_ready(mem_ready),
    .ALUop(ALUop), .ALUSrc(ALUSrc), .Reg2Loc(Reg2Loc), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch),
    .UncondBranch(UncondBranch), .instr_done(instr_done), .Illegal(Illegal),
    .state(state)
  );

  always #5 CLK = ~CLK;

  // Output vector layout: {ALUop, ALUSrc, Reg2Loc, MemRead, MemWrite,
  // MemtoReg, RegWrite, IRWrite, PCWrite, Branch, UncondBranch, instr_done, Illegal}
  localparam logic [13:0] ALU_R  = 14'h2000;
  localparam logic [13:0] ALU_Z  = 14'h1000;
  localparam logic [13:0] ASRC   = 14'h0800;
  localparam logic [13:0] R2L    = 14'h0400;
  localparam logic [13:0] MRD    = 14'h0200;
  localparam logic [13:0] MWR    = 14'h0100;
  localparam logic [13:0] M2R    = 14'h0080;
  localparam logic [13:0] RWR    = 14'h0040;
  localparam logic [13:0] IRW    = 14'h0020;
  localparam logic [13:0] PCW    = 14'h0010;
  localparam logic [13:0] BRN    = 14'h0008;
  localparam logic [13:0] UNC    = 14'h0004;
  localparam logic [13:0] DONE   = 14'h0002;
  localparam logic [13:0] ILL    = 14'h0001;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  typedef struct {
    int          st;
    logic [13:0] o;
  } exp_t;

  exp_t exp_q[$];
  int   st_log[$];
  int   ref_seq[$];
  int   checks = 0;
  int   errors = 0;
  int   cnt;
  int   abort_at;
  bit   aborted;

  function automatic int cls_of(input logic [10:0] op);
    if (op == 11'b10001011000 || op == 11'b11001011000 ||
        op == 11'b10001010000 || op == 11'b10101010000) return C_R;
    if (op == 11'b11111000010) return C_LD;
    if (op == 11'b11111000000) return C_ST;
    if (op[10:3] == 8'b10110100) return C_CBZ;
    if (op[10:5] == 6'b000101) return C_B;
    return C_ILL;
  endfunction

  function automatic logic [10:0] gen_op(input int c);
    logic [10:0] op;
    case (c)
      C_R: begin
        case ($urandom_range(0, 3))
          0: op = 11'b10001011000;
          1: op = 11'b11001011000;
          2: op = 11'b10001010000;
          default: op = 11'b10101010000;
        endcase
      end
      C_LD:  op = 11'b11111000010;
      C_ST:  op = 11'b11111000000;
      C_CBZ: op = {8'b10110100, 3'($urandom)};
      C_B:   op = {6'b000101, 5'($urandom)};
      default: begin
        op = 11'($urandom);
        while (cls_of(op) != C_ILL) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  // One clock cycle of stimulus plus the outputs that cycle must show
  task automatic step(input logic rl, input logic [10:0] op, input logic mr,
                      input int est, input logic [13:0] eo);
    exp_t e;
    if (aborted) return;
    @(posedge CLK);
    #1;
    if (cnt == abort_at) begin
      Reset_L = 1'b0;
      aborted = 1'b1;
    end else begin
      Reset_L = rl;
    end
    cnt++;
    Opcode    = op;
    mem_ready = mr;
    e.st = est;
    e.o  = eo;
    exp_q.push_back(e);
  endtask

  task automatic rst_seq(input int k);
    aborted  = 1'b0;
    abort_at = -1;
    repeat (k) step(1'b0, 11'($urandom), 1'($urandom), 0, 14'h0);
    step(1'b1, 11'($urandom), 1'($urandom), 0, 14'h0);
  endtask

  task automatic run_instr(input logic [10:0] op, input int nf, input int nm, input int ab);
    int c;
    c        = cls_of(op);
    cnt      = 0;
    abort_at = ab;
    aborted  = 1'b0;
    for (int i = 0; i < nf; i++) step(1'b1, 11'($urandom), 1'b0, 1, MRD);
    step(1'b1, 11'($urandom), 1'b1, 1, MRD | IRW | PCW);
    step(1'b1, op, 1'($urandom), 2, (c == C_ILL) ? ILL : 14'h0);
    case (c)
      C_R: begin
        step(1'b1, op, 1'($urandom), 3, ALU_R);
        step(1'b1, op, 1'($urandom), 4, RWR | DONE);
      end
      C_LD: begin
        step(1'b1, op, 1'($urandom), 5, ASRC);
        for (int i = 0; i < nm; i++) step(1'b1, op, 1'b0, 6, ASRC | MRD);
        step(1'b1, op, 1'b1, 6, ASRC | MRD);
        step(1'b1, op, 1'($urandom), 7, RWR | M2R | DONE);
      end
      C_ST: begin
        step(1'b1, op, 1'($urandom), 5, ASRC);
        for (int i = 0; i < nm; i++) step(1'b1, op, 1'b0, 6, ASRC | MWR);
        step(1'b1, op, 1'b1, 6, ASRC | MWR | DONE);
      end
      C_CBZ: step(1'b1, op, 1'($urandom), 8, ALU_Z | R2L | BRN | DONE);
      C_B:   step(1'b1, op, 1'($urandom), 9, UNC | DONE);
      default: ;
    endcase
    if (aborted) rst_seq($urandom_range(1, 3));
    abort_at = -1;
  endtask

  task automatic check_log(input string nm);
    bit bad;
    bad = (st_log.size() != ref_seq.size());
    if (!bad)
      foreach (ref_seq[i]) if (st_log[i] != ref_seq[i]) bad = 1'b1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL seq_%s: got %0d states %p, required %0d states %p",
               nm, st_log.size(), st_log, ref_seq.size(), ref_seq);
    end
  endtask

  task automatic directed(input string nm, input logic [10:0] op, input int nm_wait,
                          input int ab);
    st_log.delete();
    run_instr(op, 0, nm_wait, ab);
    @(negedge CLK);
    #1;
    check_log(nm);
  endtask

  // Compare process: every pushed cycle is checked at the falling edge
  initial begin
    exp_t        e;
    logic [13:0] got;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {ALUop, ALUSrc, Reg2Loc, MemRead, MemWrite, MemtoReg, RegWrite,
               IRWrite, PCWrite, Branch, UncondBranch, instr_done, Illegal};
        st_log.push_back(int'(state));
        checks++;
        if (int'(state) != e.st) begin
          errors++;
          $display("FAIL state @%0t: got %0d required %0d", $time, state, e.st);
        end
        checks++;
        if (got !== e.o) begin
          errors++;
          $display("FAIL outputs @%0t (state %0d): got %b required %b",
                   $time, state, got, e.o);
        end
        checks++;
        if ((MemRead && MemWrite) || (RegWrite && MemWrite)) begin
          errors++;
          $display("FAIL strobe_exclusive @%0t: MemRead=%b MemWrite=%b RegWrite=%b required no overlap",
                   $time, MemRead, MemWrite, RegWrite);
        end
      end
    end
  end

  initial begin
    int c;
    Reset_L   = 1'b0;
    Opcode    = 11'h0;
    mem_ready = 1'b0;
    abort_at  = -1;
    aborted   = 1'b0;
    cnt       = 0;

    st_log.delete();
    rst_seq(2);
    @(negedge CLK);
    #1;
    ref_seq = '{0, 0, 0};
    check_log("reset");

    ref_seq = '{1, 2, 3, 4};
    directed("add", 11'b10001011000, 0, -1);
    ref_seq = '{1, 2, 5, 6, 6, 6, 7};
    directed("ldur_wait2", 11'b11111000010, 2, -1);
    ref_seq = '{1, 2, 5, 6};
    directed("stur", 11'b11111000000, 0, -1);
    ref_seq = '{1, 2, 8};
    directed("cbz", 11'b10110100101, 0, -1);
    ref_seq = '{1, 2, 9};
    directed("b", 11'b00010111111, 0, -1);
    ref_seq = '{1, 2};
    directed("illegal", 11'b00000000000, 0, -1);

    // Reset during the second MEM wait cycle of a STUR
    abort_at = -1;
    st_log.delete();
    run_instr(11'b11111000000, 0, 3, 4);
    @(negedge CLK);
    #1;
    ref_seq = '{1, 2, 5, 6, 6};
    for (int i = 0; i < st_log.size() - 5; i++) ref_seq.push_back(0);
    check_log("stur_reset");
    ref_seq = '{1, 2, 3, 4};
    directed("add_after_reset", 11'b11001011000, 0, -1);

    for (int n = 0; n < 80; n++) begin
      c = $urandom_range(0, 5);
      run_instr(gen_op(c), $urandom_range(0, 2), $urandom_range(0, 3),
                ($urandom_range(0, 5) == 0) ? $urandom_range(0, 8) : -1);
    end

    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
